apb_fsm_controller: RTL

APB-side sequencer of the AHB2APB bridge. It takes qualified AHB transfers from `ahb_slave_interface` through `valid`, the live `haddr`/`hwrite`/`hwdata` and the decoded `temp_sel`. It converts each transfer into a two-cycle APB SETUP/ENABLE sequence and drives `hready_out` back to the AHB master, which is tied to `hready_in` at the top level. One write address arriving during a write data phase is buffered in a single-entry pending slot.

---
 rtl/apb_fsm_controller_if.sv | 29 ++
 rtl/apb_fsm_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller_if.sv
// Bus bundle between the AHB slave front end and the APB sequencer.
// The AHB-side qualified transfer comes in and the APB outputs plus hready go back.
interface apb_fsm_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [2:0]        temp_sel;
  logic [2:0]        pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hready_out;
  logic [1:0]        hresp;

  modport master (
    output valid, hwrite, haddr, hwdata, temp_sel,
    input  pselx, penable, pwrite, paddr, pwdata, hready_out, hresp
  );

  modport slave (
    input  valid, hwrite, haddr, hwdata, temp_sel,
    output pselx, penable, pwrite, paddr, pwdata, hready_out, hresp
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB2APB bridge: turns accepted AHB transfers into
// APB SETUP/ENABLE pairs, with one pending slot for an address taken during a write.
module apb_fsm_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  apb_fsm_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE
  } state_t;

  state_t            state_q;
  logic              pend_v_q;
  logic              pend_wr_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [2:0]        pend_sel_q;
  logic [ADDR_W-1:0] wa_q;
  logic [2:0]        ws_q;
  logic [2:0]        pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              hready;
  logic              accept;

  always_comb begin
    hready = 1'b1;
    case (state_q)
      READ, WRITE: hready = 1'b0;
      WENABLE:     hready = !(pend_v_q && !pend_wr_q);
      default:     hready = 1'b1;
    endcase
  end

  assign accept = bus.valid & hready;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      pend_v_q    <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_sel_q  <= '0;
      wa_q        <= '0;
      ws_q        <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      case (state_q)
        // IDLE, RENABLE and an unoccupied WENABLE share the same start-of-transfer decode
        IDLE, RENABLE, WENABLE: begin
          if (state_q == WENABLE && pend_v_q) begin
            pselx_q   <= pend_sel_q;
            paddr_q   <= pend_addr_q;
            pwrite_q  <= pend_wr_q;
            penable_q <= 1'b0;
            if (pend_wr_q) begin
              pwdata_q <= bus.hwdata;
              state_q  <= WRITE;
              pend_v_q <= accept;
              if (accept) begin
                pend_addr_q <= bus.haddr;
                pend_wr_q   <= bus.hwrite;
                pend_sel_q  <= bus.temp_sel;
              end
            end else begin
              state_q  <= READ;
              pend_v_q <= 1'b0;
            end
          end else begin
            pselx_q   <= '0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
            if (accept) begin
              if (bus.hwrite) begin
                wa_q    <= bus.haddr;
                ws_q    <= bus.temp_sel;
                state_q <= WWAIT;
              end else begin
                pselx_q  <= bus.temp_sel;
                paddr_q  <= bus.haddr;
                pwrite_q <= 1'b0;
                state_q  <= READ;
              end
            end
          end
        end
        WWAIT: begin
          pselx_q   <= ws_q;
          paddr_q   <= wa_q;
          pwdata_q  <= bus.hwdata;
          pwrite_q  <= 1'b1;
          penable_q <= 1'b0;
          state_q   <= WRITE;
          if (accept) begin
            pend_v_q    <= 1'b1;
            pend_addr_q <= bus.haddr;
            pend_wr_q   <= bus.hwrite;
            pend_sel_q  <= bus.temp_sel;
          end
        end
        READ: begin
          penable_q <= 1'b1;
          state_q   <= RENABLE;
        end
        WRITE: begin
          penable_q <= 1'b1;
          state_q   <= WENABLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pselx      = pselx_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.hready_out = hready;
  assign bus.hresp      = 2'b00;

endmodule
